// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Purpose  : Shared types, helpers and saturation constants for the
//             pipelined carry-select adder/subtractor (csa_pipe).
//             The saturation helpers are only used when CSA_PIPE_SAT_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package csa_pkg;

  // Widest operand the saturation helpers can describe.
  localparam int CSA_MAX_W = 64;

  // Per-operation tags carried alongside the data through the pipeline.
  typedef struct packed {
    logic sub;
    logic sat;
    logic a_msb;
  } csa_tag_t;

  // Number of segments (and pipeline stages) for a given split.
  function automatic int csa_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Largest positive two's-complement value of the given width: {0, 1...1}.
  function automatic logic [CSA_MAX_W-1:0] csa_max_pos(input int width);
    return (CSA_MAX_W'(1) << (width - 1)) - CSA_MAX_W'(1);
  endfunction

  // Most negative two's-complement value of the given width: {1, 0...0}.
  function automatic logic [CSA_MAX_W-1:0] csa_min_neg(input int width);
    return CSA_MAX_W'(1) << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_seg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_seg
//  Purpose  : Combinational SEG_W-bit carry-select segment. Two ripple sums
//             (carry-in 0 and 1) are formed in parallel and the late carry
//             only drives the final select mux. Also reports the carry into
//             the segment MSB so the top segment can derive signed overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [SEG_W-1:0] s0, s1;
  logic             c0, c1, m0, m1;

  // Dual ripple chains, one assuming carry-in 0, the other carry-in 1.
  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    m0 = 1'b0;
    m1 = 1'b0;
    for (int i = 0; i < SEG_W; i++) begin
      if (i == SEG_W - 1) begin
        m0 = c0;
        m1 = c1;
      end
      s0[i] = a[i] ^ b[i] ^ c0;
      s1[i] = a[i] ^ b[i] ^ c1;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
  end

  // Late-arriving carry picks one of the precomputed results.
  assign sum  = cin ? s1 : s0;
  assign co   = cin ? c1 : c0;
  assign cmsb = cin ? m1 : m0;

endmodule
`default_nettype wire

// File: rtl/csa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pipe
//  Purpose  : Pipelined carry-select adder/subtractor. A WIDTH-bit operation
//             is split into NSEG = WIDTH/SEG_W segments, one resolved per
//             stage, under a global valid/ready stall.
//             Optional feature macro: CSA_PIPE_SAT_EN (adds the sat port and
//             signed saturation of the result on overflow).
//  Revision : 1.0 - initial release
// ============================================================================
module csa_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
`ifdef CSA_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf
);

  localparam int NSEG = csa_nseg(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("csa_pipe: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end

  logic             advance;
  logic [WIDTH-1:0] b_form;
  logic             cin_form;
  logic             ovf_d, ovf_q;

  // Subtraction is A + ~B + 1; the carry-in from the port only applies to add.
  always_comb begin
    b_form   = sub ? ~b : b;
    cin_form = sub ? 1'b1 : ci;
  end

  // Whole pipeline moves together; it may move whenever the output slot frees.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int RES_W = (k + 1) * SEG_W;

    logic             take;
    logic [SEG_W-1:0] seg_a, seg_b, seg_sum;
    logic             seg_cin, seg_co, seg_cmsb;
    logic [RES_W-1:0] res_new, res_d, res_q;
    logic             valid_d, valid_q, c_d, c_q;
`ifdef CSA_PIPE_SAT_EN
    csa_tag_t         tag_new, tag_d, tag_q;
`endif

    // Stage 0 is fed from the formed operands; later stages from the
    // operand bits still waiting in the previous stage register.
    if (k == 0) begin : g_src
      assign take    = in_valid;
      assign seg_a   = a[SEG_W-1:0];
      assign seg_b   = b_form[SEG_W-1:0];
      assign seg_cin = cin_form;
      assign res_new = seg_sum;
`ifdef CSA_PIPE_SAT_EN
      assign tag_new = {sub, sat, a[WIDTH-1]};
`endif
    end else begin : g_src
      assign take    = g_stage[k-1].valid_q;
      assign seg_a   = g_stage[k-1].g_rem.rem_a_q[SEG_W-1:0];
      assign seg_b   = g_stage[k-1].g_rem.rem_b_q[SEG_W-1:0];
      assign seg_cin = g_stage[k-1].c_q;
      assign res_new = {seg_sum, g_stage[k-1].res_q};
`ifdef CSA_PIPE_SAT_EN
      assign tag_new = g_stage[k-1].tag_q;
`endif
    end

    csa_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_cin),
      .sum  (seg_sum),
      .co   (seg_co),
      .cmsb (seg_cmsb)
    );

    // Capture the resolved segment on advance; bubbles keep old data so the
    // output holds its last value while out_valid is low.
    always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      c_d     = c_q;
`ifdef CSA_PIPE_SAT_EN
      tag_d   = tag_q;
`endif
      if (advance) begin
        valid_d = take;
        if (take) begin
          res_d = res_new;
          c_d   = seg_co;
`ifdef CSA_PIPE_SAT_EN
          tag_d = tag_new;
`endif
        end
      end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        valid_q <= 1'b0;
        res_q   <= '0;
        c_q     <= 1'b0;
`ifdef CSA_PIPE_SAT_EN
        tag_q   <= '0;
`endif
      end else begin
        valid_q <= valid_d;
        res_q   <= res_d;
        c_q     <= c_d;
`ifdef CSA_PIPE_SAT_EN
        tag_q   <= tag_d;
`endif
      end
    end

    // Operand bits for the segments not yet resolved; the last stage has none.
    if (k < NSEG - 1) begin : g_rem
      localparam int REM_W = WIDTH - RES_W;
      logic [REM_W-1:0] rem_a_new, rem_b_new, rem_a_d, rem_b_d, rem_a_q, rem_b_q;

      if (k == 0) begin : g_from
        assign rem_a_new = a[WIDTH-1:SEG_W];
        assign rem_b_new = b_form[WIDTH-1:SEG_W];
      end else begin : g_from
        assign rem_a_new = g_stage[k-1].g_rem.rem_a_q[REM_W+SEG_W-1:SEG_W];
        assign rem_b_new = g_stage[k-1].g_rem.rem_b_q[REM_W+SEG_W-1:SEG_W];
      end

      // Pending operand bits move with the operation they belong to.
      always_comb begin
        rem_a_d = rem_a_q;
        rem_b_d = rem_b_q;
        if (advance && take) begin
          rem_a_d = rem_a_new;
          rem_b_d = rem_b_new;
        end
      end

      // Pending operand register.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (advance && g_stage[NSEG-1].take) begin
      ovf_d = g_stage[NSEG-1].seg_cmsb ^ g_stage[NSEG-1].seg_co;
    end
  end

  // Overflow flag register for the final stage.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_q;
  assign co        = g_stage[NSEG-1].c_q;
  assign ovf       = ovf_q;

`ifdef CSA_PIPE_SAT_EN
  if (WIDTH > CSA_MAX_W) begin : g_bad_sat_width
    $error("csa_pipe: saturation supports WIDTH up to %0d", CSA_MAX_W);
  end

  localparam logic [CSA_MAX_W-1:0] MAX_POS_FULL = csa_max_pos(WIDTH);
  localparam logic [CSA_MAX_W-1:0] MIN_NEG_FULL = csa_min_neg(WIDTH);
  localparam logic [WIDTH-1:0]     MAX_POS      = MAX_POS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     MIN_NEG      = MIN_NEG_FULL[WIDTH-1:0];

  // Clamp toward the sign of A when a saturating op overflows; co/ovf stay raw.
  always_comb begin
    out = g_stage[NSEG-1].res_q;
    if (g_stage[NSEG-1].tag_q.sat && ovf_q) begin
      out = g_stage[NSEG-1].tag_q.a_msb ? MIN_NEG : MAX_POS;
    end
  end
`else
  assign out = g_stage[NSEG-1].res_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_pipe
//  Purpose  : Scoreboard bench for csa_pipe (WIDTH=32, SEG_W=8). Accepted
//             operations push an arithmetic reference result; a monitor pops
//             and compares on every output transfer and checks hold-under-stall.
//             Saturation cases run only when CSA_PIPE_SAT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_pipe;

  typedef struct packed {
    logic [31:0] out;
    logic        co;
    logic        ovf;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        co;
  logic        ovf;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  csa_pipe #(
    .WIDTH (32),
    .SEG_W (8)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
`ifdef CSA_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Reference result from integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi,
                                 input logic cii, input logic subi, input logic sati);
    exp_t            e;
    longint          s;
    longint unsigned u;
    if (subi) begin
      s     = longint'($signed(ai)) - longint'($signed(bi));
      e.out = ai - bi;
      e.co  = (ai >= bi);
    end else begin
      s     = longint'($signed(ai)) + longint'($signed(bi)) + longint'(cii);
      u     = longint'(ai) + longint'(bi) + longint'(cii);
      e.out = u[31:0];
      e.co  = u[32];
    end
    e.ovf = (s > SMAX) || (s < SMIN);
    if (sati && e.ovf) e.out = (s > SMAX) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return e;
  endfunction

  // One cycle of stimulus; reports whether the op will be accepted at the next edge.
  task automatic drive(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                       input logic cii, input logic subi, input logic sati,
                       input logic ordy, output logic acc);
    @(negedge clock);
    in_valid  = v;
    a         = ai;
    b         = bi;
    ci        = cii;
    sub       = subi;
    sat       = sati;
    out_ready = ordy;
    #1;
    acc = v && in_ready && resetn;
    if (acc) exp_q.push_back(model(ai, bi, cii, subi, sati));
  endtask

  task automatic send(input logic [31:0] ai, input logic [31:0] bi, input logic cii,
                      input logic subi, input logic sati, input logic ordy);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      drive(1'b1, ai, bi, cii, subi, sati, ordy, acc);
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: op a=%h b=%h not accepted, in_ready=%b", ai, bi, in_ready);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, acc);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Monitor: compare every output transfer, and hold stability while stalled.
  initial begin : monitor
    logic        held;
    logic [31:0] h_out;
    logic        h_co, h_ovf;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!resetn) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_out",   out, h_out);
          chk("stall_co_ovf", {30'd0, co, ovf}, {30'd0, h_co, h_ovf});
        end
        if (out_valid && out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: out=%h co=%b ovf=%b, none expected", out, co, ovf);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out", out, e.out);
            chk("sb_co",  {31'd0, co},  {31'd0, e.co});
            chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
          end
        end else if (out_valid) begin
          held  = 1'b1;
          h_out = out;
          h_co  = co;
          h_ovf = ovf;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic acc;
    int   lat, cnt, first, last, waited;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out",       out, 32'd0);
    chk("rst_co_ovf",    {30'd0, co, ovf}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    resetn = 1'b1;

    // Latency and positive overflow on add
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    chk("latency",     lat, 32'd4);
    chk("add_ovf_out", out, 32'h8000_0000);
    chk("add_ovf_flags", {30'd0, co, ovf}, {30'd0, 1'b0, 1'b1});
    idle(6, 1'b1);

    // Back-to-back: subtracts and full carry ripple, one result per cycle
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1);
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      if (out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_count",  cnt, 32'd4);
    chk("b2b_spread", last - first, 32'd3);

    // Stall with a full pipeline
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    idle(8, 1'b1);
    chk("stall_drain", exp_q.size(), 32'd0);

`ifdef CSA_PIPE_SAT_EN
    // Saturation
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8, 1'b1);
`endif

    // Reset with three operations in flight, plus a simultaneous input
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0055, 32'h0000_0066, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    resetn   = 1'b0;
    in_valid = 1'b1;
    a        = 32'hDEAD_BEEF;
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_out",       out, 32'd0);
    chk("rst2_co_ovf",    {30'd0, co, ovf}, 32'd0);
    chk("rst2_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    resetn   = 1'b1;
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      if (out_valid) cnt++;
    end
    chk("rst2_no_stale", cnt, 32'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
`ifdef CSA_PIPE_SAT_EN
            1'($urandom_range(0, 1)),
`else
            1'b0,
`endif
            $urandom_range(0, 3) != 0, acc);
    end

    // Drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      idle(1, 1'b1);
      waited++;
    end
    idle(2, 1'b1);
    chk("final_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
